switch_conditioner: RTL and testbench
=====================================

// Module: switch_conditioner
// PURPOSE
//  Multi-channel front end for board slide switches / push buttons (start, pause, mode).
//  Per channel: metastability synchroniser, counter-based debouncer, edge pulses, optional toggle latch.
//  Sits between top-level pins and the game/control FSMs; replaces raw combinational switch decode.
// PARAMETERS
//  NUM_CH          4        number of independent channels
//  SYNC_STAGES     2        flip-flops in synchroniser chain (>=2)
//  DEBOUNCE_CYCLES 1000000  consecutive cycles input must differ from stable value before accepted (>=1; 10 ms @100 MHz)
//  TOGGLE_MASK     4'b0000  bit i=1: state[i] toggles on each debounced rise; bit i=0: state[i] follows level[i]
//  HOLD_CYCLES     200000000 long-press threshold in cycles (used only with SWCOND_LONGPRESS_EN)
// PORTS
//  clk         in   1       system clock
//  rst_n       in   1       asynchronous active-low reset
//  sw_in       in   NUM_CH  raw asynchronous switch/button pins
//  clr         in   1       synchronous clear of all toggle latches
//  level       out  NUM_CH  debounced stable level
//  rise        out  NUM_CH  1-cycle pulse on debounced 0->1
//  fall        out  NUM_CH  1-cycle pulse on debounced 1->0
//  state       out  NUM_CH  toggle latch or level, per TOGGLE_MASK
//  hold        out  NUM_CH  1-cycle long-press pulse (0 when feature compiled out)
// BEHAVIOUR
//  - One clock (clk); reset asynchronous, active-low (rst_n). All flops clear on rst_n=0.
//  - Reset values: sync chain 0, level 0, rise 0, fall 0, state 0, hold 0, all counters 0.
//  - Reset mid-debounce/mid-hold: counters discarded; after release channel restarts from level=0.
//  - Sync: sync_q = sw_in delayed SYNC_STAGES clocks.
//  - Debounce per channel, counter width $clog2(DEBOUNCE_CYCLES+1):
//    sync_q==level -> cnt<=0.
//    sync_q!=level and cnt<DEBOUNCE_CYCLES-1 -> cnt<=cnt+1.
//    sync_q!=level and cnt==DEBOUNCE_CYCLES-1 -> level<=sync_q, cnt<=0.
//    Any glitch back to level value before threshold resets cnt; no partial credit.
//    DEBOUNCE_CYCLES=1: level follows sync_q with 1 cycle delay.
//  - Latency: clean pin edge to level change = SYNC_STAGES+DEBOUNCE_CYCLES clocks.
//  - rise[i]/fall[i]: registered, asserted high for exactly one cycle.
//    Asserted in the first cycle level[i] shows its new value.
//  - state[i], TOGGLE_MASK[i]=1:
//    Inverts in the cycle after rise[i].
//    clr=1 forces state to 0 for all toggle channels; clr wins over a simultaneous rise.
//  - state[i], TOGGLE_MASK[i]=0: state[i]=level[i] combinationally; clr has no effect.
//  - Channels fully independent; simultaneous events on several channels all honoured the same cycle.
// CONFIGURATION
//  SWCOND_LONGPRESS_EN defined:
//    Per-channel hold counter; counts while level[i]=1; clears when level[i]=0.
//    hold[i] pulses one cycle when count reaches HOLD_CYCLES-1.
//    Counter then saturates, so at most one hold pulse per press.
//  SWCOND_LONGPRESS_EN undefined: no hold counters synthesised; hold tied to 0; port list unchanged.
// TESTING  (NUM_CH=4, SYNC_STAGES=2, DEBOUNCE_CYCLES=4, TOGGLE_MASK=4'b0010, HOLD_CYCLES=10)
//  1 rst_n=0 with sw_in=4'hF, release -> all outputs 0; level[3:0]=4'hF exactly 6 clocks after release; rise=4'hF one cycle.
//  2 sw_in[0] high 3 cycles then low (glitch) -> level[0], rise[0] stay 0; then high 10 cycles -> level[0]=1 at +6, rise[0] one pulse.
//  3 ch1 pressed/released twice (each stable >=8 cycles) -> state[1] 0->1->0; one toggle per press, none on release; fall[1] pulses on each release.
//  4 clr asserted in same cycle as rise[1] with state[1]=0 -> state[1] stays 0; clr with state[1]=1 -> 0 next cycle; state[0] unaffected.
//  5 rst_n pulsed low mid-debounce (cnt=2) on ch2 -> level[2]=0; after release full 6-clock latency needed again.
//  6 LONGPRESS_EN: ch3 held 25 cycles after level -> single hold[3] pulse 10 cycles after level rose; without macro hold=0 throughout.

Source files
------------

// File: rtl/switch_conditioner.sv
// switch_conditioner: per-channel synchroniser, debouncer, edge pulses and toggle latch for switches/buttons.
// Define SWCOND_LONGPRESS_EN to build the per-channel long-press (hold) detector.
module switch_conditioner #(
   parameter int                NUM_CH          = 4,
   parameter int                SYNC_STAGES     = 2,
   parameter int                DEBOUNCE_CYCLES = 1000000,
   parameter logic [NUM_CH-1:0] TOGGLE_MASK     = '0,
   parameter int                HOLD_CYCLES     = 200000000
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [NUM_CH-1:0] sw_in,
   input  logic              clr,
   output logic [NUM_CH-1:0] level,
   output logic [NUM_CH-1:0] rise,
   output logic [NUM_CH-1:0] fall,
   output logic [NUM_CH-1:0] state,
   output logic [NUM_CH-1:0] hold
);
   localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
   logic [NUM_CH-1:0] sync_r [SYNC_STAGES];
   logic [CW-1:0]     cnt    [NUM_CH];
   logic [NUM_CH-1:0] sync_q;
   logic [NUM_CH-1:0] tog;
   if (SYNC_STAGES < 2 || DEBOUNCE_CYCLES < 1 || HOLD_CYCLES < 1) begin : g_bad_param
      $error("switch_conditioner: illegal parameter value");
   end
   assign sync_q = sync_r[SYNC_STAGES-1];
   assign state  = (tog & TOGGLE_MASK) | (level & ~TOGGLE_MASK);
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int s = 0; s < SYNC_STAGES; s++) sync_r[s] <= '0;
         for (int i = 0; i < NUM_CH; i++) cnt[i] <= '0;
         level <= '0;
         rise  <= '0;
         fall  <= '0;
         tog   <= '0;
      end else begin
         sync_r[0] <= sw_in;
         for (int s = 1; s < SYNC_STAGES; s++) sync_r[s] <= sync_r[s-1];
         rise <= '0;
         fall <= '0;
         for (int i = 0; i < NUM_CH; i++) begin
            if (sync_q[i] == level[i]) begin
               cnt[i] <= '0;
            end else if (cnt[i] == CW'(DEBOUNCE_CYCLES - 1)) begin
               cnt[i]   <= '0;
               level[i] <= sync_q[i];
               rise[i]  <= sync_q[i];
               fall[i]  <= ~sync_q[i];
            end else begin
               cnt[i] <= cnt[i] + 1'b1;
            end
         end
         // clr beats a rise landing in the same cycle
         tog <= clr ? '0 : (tog ^ rise) & TOGGLE_MASK;
      end
   end
`ifdef SWCOND_LONGPRESS_EN
   localparam int HW = $clog2(HOLD_CYCLES + 1);
   logic [HW-1:0] hcnt [NUM_CH];
   // counter parks at HOLD_CYCLES so a press yields at most one pulse
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < NUM_CH; i++) hcnt[i] <= '0;
         hold <= '0;
      end else begin
         for (int i = 0; i < NUM_CH; i++) begin
            hcnt[i] <= !level[i] ? '0 : (hcnt[i] == HW'(HOLD_CYCLES)) ? hcnt[i] : hcnt[i] + 1'b1;
            hold[i] <= level[i] && (hcnt[i] == HW'(HOLD_CYCLES - 1));
         end
      end
   end
`else
   assign hold = '0;
`endif
endmodule

// File: tb/tb_switch_conditioner.sv
// tb_switch_conditioner: table-driven checks of debounce latency, edges, toggle/clr, reset and long-press.
module tb_switch_conditioner;
   logic       clk = 1'b0;
   logic       rst_n;
   logic [3:0] sw_in;
   logic       clr;
   logic [3:0] level, rise, fall, state, hold;
   int total = 0;
   int fails = 0;

   typedef struct {
      logic [3:0] sw;
      logic       clr;
      logic [3:0] lvl;
      logic [3:0] rs;
      logic [3:0] fl;
      logic [3:0] st;
   } vec_t;
   vec_t vecs[$];

   switch_conditioner #(
      .NUM_CH(4), .SYNC_STAGES(2), .DEBOUNCE_CYCLES(4),
      .TOGGLE_MASK(4'b0010), .HOLD_CYCLES(10)
   ) dut (
      .clk(clk), .rst_n(rst_n), .sw_in(sw_in), .clr(clr),
      .level(level), .rise(rise), .fall(fall), .state(state), .hold(hold)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string nm, input logic [3:0] act, input logic [3:0] exp);
      total++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s got %h expected %h at %0t", nm, act, exp, $time);
      end
   endtask

   function automatic void add(input logic [3:0] sw, input logic c, input logic [3:0] lvl,
                               input logic [3:0] rs, input logic [3:0] fl, input logic [3:0] st);
      vecs.push_back('{sw: sw, clr: c, lvl: lvl, rs: rs, fl: fl, st: st});
   endfunction

   // drive sw for 6 cycles (2 sync + 4 debounce) then extra settled cycles
   function automatic void add_edge(input logic [3:0] sw, input logic [3:0] old_l, input logic [3:0] new_l,
                                    input logic [3:0] st_old, input logic [3:0] st6,
                                    input logic [3:0] st_after, input int extra);
      for (int k = 0; k < 5; k++) add(sw, 1'b0, old_l, 4'h0, 4'h0, st_old);
      add(sw, 1'b0, new_l, new_l & ~old_l, old_l & ~new_l, st6);
      for (int k = 0; k < extra; k++) add(sw, 1'b0, new_l, 4'h0, 4'h0, st_after);
   endfunction

   initial begin
      int hold_cnt;
      logic [3:0] hexp;
      rst_n = 1'b0;
      sw_in = 4'hF;
      clr   = 1'b0;
      repeat (3) tick();
      chk("rst_level", level, 4'h0);
      chk("rst_rise", rise, 4'h0);
      chk("rst_fall", fall, 4'h0);
      chk("rst_state", state, 4'h0);
      chk("rst_hold", hold, 4'h0);
      rst_n = 1'b1;

      add_edge(4'hF, 4'h0, 4'hF, 4'h0, 4'hD, 4'hF, 2);
      add_edge(4'h0, 4'hF, 4'h0, 4'hF, 4'h2, 4'h2, 1);
      add(4'h0, 1'b1, 4'h0, 4'h0, 4'h0, 4'h0);
      add(4'h0, 1'b0, 4'h0, 4'h0, 4'h0, 4'h0);
      for (int k = 0; k < 3; k++) add(4'h1, 1'b0, 4'h0, 4'h0, 4'h0, 4'h0);
      for (int k = 0; k < 4; k++) add(4'h0, 1'b0, 4'h0, 4'h0, 4'h0, 4'h0);
      add_edge(4'h1, 4'h0, 4'h1, 4'h0, 4'h1, 4'h1, 4);
      add_edge(4'h3, 4'h1, 4'h3, 4'h1, 4'h1, 4'h3, 3);
      add_edge(4'h1, 4'h3, 4'h1, 4'h3, 4'h3, 4'h3, 2);
      add_edge(4'h3, 4'h1, 4'h3, 4'h3, 4'h3, 4'h1, 2);
      add_edge(4'h1, 4'h3, 4'h1, 4'h1, 4'h1, 4'h1, 2);
      add_edge(4'h3, 4'h1, 4'h3, 4'h1, 4'h1, 4'h1, 0);
      add(4'h3, 1'b1, 4'h3, 4'h0, 4'h0, 4'h1);
      add(4'h3, 1'b0, 4'h3, 4'h0, 4'h0, 4'h1);

      foreach (vecs[n]) begin
         sw_in = vecs[n].sw;
         clr   = vecs[n].clr;
         tick();
         chk($sformatf("v%0d_level", n), level, vecs[n].lvl);
         chk($sformatf("v%0d_rise", n), rise, vecs[n].rs);
         chk($sformatf("v%0d_fall", n), fall, vecs[n].fl);
         chk($sformatf("v%0d_state", n), state, vecs[n].st);
`ifndef SWCOND_LONGPRESS_EN
         chk($sformatf("v%0d_hold", n), hold, 4'h0);
`endif
      end
      clr = 1'b0;

      // reset in the middle of a debounce, then a full restart and long press
      sw_in = 4'hF;
      repeat (4) tick();
      chk("mid_level", level, 4'h3);
      rst_n = 1'b0;
      #1;
      chk("async_rst_level", level, 4'h0);
      chk("async_rst_state", state, 4'h0);
      tick();
      rst_n = 1'b1;
      for (int k = 1; k <= 5; k++) begin
         tick();
         chk($sformatf("restart_wait%0d", k), level, 4'h0);
      end
      tick();
      chk("restart_level", level, 4'hF);
      chk("restart_rise", rise, 4'hF);
      hold_cnt = 0;
      for (int k = 1; k <= 25; k++) begin
         tick();
`ifdef SWCOND_LONGPRESS_EN
         hexp = (k == 10) ? 4'hF : 4'h0;
`else
         hexp = 4'h0;
`endif
         if (hold[3]) hold_cnt++;
         chk($sformatf("hold_k%0d", k), hold, hexp);
      end
`ifdef SWCOND_LONGPRESS_EN
      chk("hold_pulses", 4'(hold_cnt), 4'd1);
`else
      chk("hold_pulses", 4'(hold_cnt), 4'd0);
`endif
      chk("final_level", level, 4'hF);
      $display("%0d/%0d checks passed", total - fails, total);
      $finish;
   end
endmodule
